undo_log_capture: RTL
=====================

Name: undo_log_capture

Overview:
- Per-core front end that feeds the tile's undo log.
- For every speculative store it:
  - reads the old memory word;
  - emits an undo entry (addr, old data, per-task id, CQ slot);
  - only after the entry is accepted, forwards the store to memory.
- On task finish it reports the slot and whether any undo entry was written, which drives the undo log's finish_task_* inputs.
- One instance per core. Its undo_log_* outputs connect to one lane of the undo log's N_CORES-wide log interface.

Parameters:
- CORE_ID, 0, core index; used as the AXI ARID base.
- ENTRIES_PER_TASK, 2**LOG_UNDO_LOG_ENTRIES_PER_TASK, maximum undo entries per task.
- ID_BASE, 0, OR'd into the read-request ARID.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- task_start_valid  in  1  core begins a task
- task_start_slot  in  cq_slice_slot_t  CQ slot of the new task
- task_abort  in  1  discard the current task's capture state
- st_valid  in  1  store request from the core
- st_ready  out  1  store accepted
- st_addr  in  undo_log_addr_t  store address (word aligned)
- st_data  in  undo_log_data_t  new data
- rd_arvalid  out  1  old-value read request
- rd_arready  in  1  read request accepted
- rd_araddr  out  undo_log_addr_t  read address
- rd_arid  out  16  ID_BASE | CORE_ID
- rd_rvalid  in  1  read data valid
- rd_rready  out  1  read data accepted
- rd_rdata  in  undo_log_data_t  old data
- undo_log_valid  out  1  undo entry valid
- undo_log_ready  in  1  undo entry accepted
- undo_log_id  out  undo_id_t  entry index within the task
- undo_log_addr  out  undo_log_addr_t  entry address
- undo_log_data  out  undo_log_data_t  old data
- undo_log_slot  out  cq_slice_slot_t  task CQ slot
- wr_valid  out  1  forwarded store valid
- wr_ready  in  1  forwarded store accepted
- wr_addr  out  undo_log_addr_t  forwarded store address
- wr_data  out  undo_log_data_t  forwarded store data
- task_finish_valid  in  1  core finishes the task
- task_finish_ready  out  1  finish accepted
- finish_task_valid  out  1  finish notification to the undo log
- finish_task_slot  out  cq_slice_slot_t  slot of the finished task
- finish_task_undo_log_write  out  1  task wrote at least one entry
- overflow  out  1  sticky: a store was attempted with the entry budget exhausted

Behaviour:
- Reset: state IDLE, entry count 0, cur_slot 0, overflow 0. All valid/ready outputs 0.
- Task start:
  - task_start_valid latches cur_slot and clears the count.
  - It is legal only in IDLE; elsewhere it is ignored and flagged by an assertion.
- FSM states: IDLE, RD_ADDR, RD_DATA, LOG, WRITE.
- IDLE:
  - st_ready = st_valid & (count < ENTRIES_PER_TASK) & !task_finish_valid.
  - On accept: latch addr/data, go to RD_ADDR.
  - If st_valid and count == ENTRIES_PER_TASK: st_ready stays 0 and overflow is set; it is cleared by task_abort or task_start_valid.
- RD_ADDR: rd_arvalid = 1 with latched addr. On rd_arready go to RD_DATA.
- RD_DATA: rd_rready = 1. On rd_rvalid latch rd_rdata and go to LOG.
- LOG:
  - undo_log_valid = 1, id = count, addr = latched addr, data = old data, slot = cur_slot.
  - On undo_log_ready: count += 1, go to WRITE.
- WRITE: wr_valid = 1 with the new data. On wr_ready go to IDLE.
- Ordering:
  - The log entry handshake always completes before wr_valid rises.
  - Minimum store latency is 4 cycles with all readies high and 1-cycle read data.
  - Outputs hold stable while valid is high and ready is low.
- Finish:
  - task_finish_ready = (state == IDLE).
  - On accept, the next cycle drives finish_task_valid = 1 for exactly one cycle, with slot = cur_slot and undo_log_write = (count != 0). The count then clears.
  - Simultaneous st_valid and task_finish_valid in IDLE: finish wins, and the store is not accepted that cycle.
- task_abort:
  - Returns to IDLE from any state and clears count and overflow.
  - An in-flight read response that arrives later is drained: rd_rready is held 1 until rvalid is seen, tracked by a pending flag.
  - An undo entry already accepted is not retracted.
- Width rules:
  - count is $clog2(ENTRIES_PER_TASK)+1 bits.
  - undo_log_id = count[$clog2(ENTRIES_PER_TASK)-1:0], so the last entry id is ENTRIES_PER_TASK-1 and ids never wrap.
- Mid-operation rstn: returns to IDLE immediately and all valids are 0 on the next cycle.

Decomposition:
- Types from the chronos package: undo_log_addr_t, undo_log_data_t, undo_id_t, cq_slice_slot_t, LOG_UNDO_LOG_ENTRIES_PER_TASK.
- Add capture_state_t to the package for debug visibility.
- No sub-module. Single FSM plus count and pending-read flag.

Test Plan:
- Start slot 5; store addr 0x100 = 0xAA, memory holds 0x11 -> undo entry (id 0, 0x100, 0x11, slot 5), then write (0x100, 0xAA). wr_valid never precedes the log handshake.
- 3 stores, then finish -> ids 0, 1, 2; one-cycle finish_task_valid, slot 5, undo_log_write = 1.
- Start slot 9, finish with no stores -> finish_task_undo_log_write = 0, no undo_log_valid.
- ENTRIES_PER_TASK = 4, fifth store -> st_ready stays 0, overflow = 1; task_abort -> overflow = 0, state IDLE.
- undo_log_ready low for 10 cycles in LOG -> entry fields stable, wr_valid = 0 throughout.
- task_abort in RD_DATA, rvalid arrives 3 cycles later -> response drained, no undo entry or write emitted, next store proceeds normally.

Source files
------------

// File: rtl/undo_log_capture_pkg.sv
// Shared types for the per-core undo-log capture front end.
package undo_log_capture_pkg;

  localparam int unsigned LOG_UNDO_LOG_ENTRIES_PER_TASK = 2;
  localparam int unsigned UNDO_LOG_ADDR_W = 32;
  localparam int unsigned UNDO_LOG_DATA_W = 32;
  localparam int unsigned CQ_SLICE_SLOT_W = 7;

  typedef logic [UNDO_LOG_ADDR_W-1:0]               undo_log_addr_t;
  typedef logic [UNDO_LOG_DATA_W-1:0]               undo_log_data_t;
  typedef logic [LOG_UNDO_LOG_ENTRIES_PER_TASK-1:0] undo_id_t;
  typedef logic [CQ_SLICE_SLOT_W-1:0]               cq_slice_slot_t;

  typedef enum logic [2:0] {
    CAP_IDLE,
    CAP_RD_ADDR,
    CAP_RD_DATA,
    CAP_LOG,
    CAP_WRITE
  } capture_state_t;

endpackage

// File: rtl/undo_log_capture.sv
// Captures old memory values of speculative stores into the undo log
// before forwarding each store, and reports task finish to the log.
module undo_log_capture
  import undo_log_capture_pkg::*;
#(
  parameter int unsigned CORE_ID          = 0,
  parameter int unsigned ENTRIES_PER_TASK = 2**LOG_UNDO_LOG_ENTRIES_PER_TASK,
  parameter int unsigned ID_BASE          = 0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           task_start_valid,
  input  cq_slice_slot_t task_start_slot,
  input  logic           task_abort,
  input  logic           st_valid,
  output logic           st_ready,
  input  undo_log_addr_t st_addr,
  input  undo_log_data_t st_data,
  output logic           rd_arvalid,
  input  logic           rd_arready,
  output undo_log_addr_t rd_araddr,
  output logic [15:0]    rd_arid,
  input  logic           rd_rvalid,
  output logic           rd_rready,
  input  undo_log_data_t rd_rdata,
  output logic           undo_log_valid,
  input  logic           undo_log_ready,
  output undo_id_t       undo_log_id,
  output undo_log_addr_t undo_log_addr,
  output undo_log_data_t undo_log_data,
  output cq_slice_slot_t undo_log_slot,
  output logic           wr_valid,
  input  logic           wr_ready,
  output undo_log_addr_t wr_addr,
  output undo_log_data_t wr_data,
  input  logic           task_finish_valid,
  output logic           task_finish_ready,
  output logic           finish_task_valid,
  output cq_slice_slot_t finish_task_slot,
  output logic           finish_task_undo_log_write,
  output logic           overflow
);

  localparam int unsigned IW = $clog2(ENTRIES_PER_TASK);
  localparam int unsigned CW = IW + 1;

  capture_state_t state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  cq_slice_slot_t slot_q, slot_d;
  logic           ovf_q, ovf_d;
  logic           pend_q, pend_d;
  undo_log_addr_t addr_q, addr_d;
  undo_log_data_t wdata_q, wdata_d;
  undo_log_data_t old_q, old_d;
  logic           fin_valid_q, fin_valid_d;
  cq_slice_slot_t fin_slot_q, fin_slot_d;
  logic           fin_write_q, fin_write_d;
  logic           room;
  logic           can_store;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= CAP_IDLE;
      count_q     <= '0;
      slot_q      <= '0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      old_q       <= '0;
      fin_valid_q <= 1'b0;
      fin_slot_q  <= '0;
      fin_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      slot_q      <= slot_d;
      ovf_q       <= ovf_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      old_q       <= old_d;
      fin_valid_q <= fin_valid_d;
      fin_slot_q  <= fin_slot_d;
      fin_write_q <= fin_write_d;
    end
  end

  // Next-state logic; abort is applied last so it overrides every state
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    slot_d      = slot_q;
    ovf_d       = ovf_q;
    pend_d      = pend_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    old_d       = old_q;
    fin_valid_d = 1'b0;
    fin_slot_d  = fin_slot_q;
    fin_write_d = fin_write_q;
    room        = count_q < CW'(ENTRIES_PER_TASK);
    // A store waits while an abandoned read response is still outstanding
    can_store   = (state_q == CAP_IDLE) && st_valid && room && !task_finish_valid
                  && !task_abort && !task_start_valid && !pend_q;

    if (pend_q && rd_rvalid) pend_d = 1'b0;

    unique case (state_q)
      CAP_IDLE: begin
        if (task_finish_valid) begin
          fin_valid_d = 1'b1;
          fin_slot_d  = slot_q;
          fin_write_d = (count_q != '0);
          count_d     = '0;
        end else if (can_store) begin
          addr_d  = st_addr;
          wdata_d = st_data;
          state_d = CAP_RD_ADDR;
        end else if (st_valid && !room) begin
          ovf_d = 1'b1;
        end
        if (task_start_valid) begin
          slot_d  = task_start_slot;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      CAP_RD_ADDR: if (rd_arready) state_d = CAP_RD_DATA;
      CAP_RD_DATA: begin
        if (rd_rvalid) begin
          old_d   = rd_rdata;
          state_d = CAP_LOG;
        end
      end
      CAP_LOG: begin
        if (undo_log_ready) begin
          count_d = count_q + CW'(1);
          state_d = CAP_WRITE;
        end
      end
      CAP_WRITE: if (wr_ready) state_d = CAP_IDLE;
      default: state_d = CAP_IDLE;
    endcase

    if (task_abort) begin
      state_d = CAP_IDLE;
      count_d = '0;
      ovf_d   = 1'b0;
      if ((state_q == CAP_RD_ADDR && rd_arready) || (state_q == CAP_RD_DATA && !rd_rvalid))
        pend_d = 1'b1;
    end
  end

  assign st_ready                   = can_store;
  assign rd_arvalid                 = (state_q == CAP_RD_ADDR);
  assign rd_araddr                  = addr_q;
  assign rd_arid                    = 16'(ID_BASE) | 16'(CORE_ID);
  assign rd_rready                  = (state_q == CAP_RD_DATA) || pend_q;
  assign undo_log_valid             = (state_q == CAP_LOG);
  assign undo_log_id                = undo_id_t'(count_q[IW-1:0]);
  assign undo_log_addr              = addr_q;
  assign undo_log_data              = old_q;
  assign undo_log_slot              = slot_q;
  assign wr_valid                   = (state_q == CAP_WRITE);
  assign wr_addr                    = addr_q;
  assign wr_data                    = wdata_q;
  assign task_finish_ready          = (state_q == CAP_IDLE);
  assign finish_task_valid          = fin_valid_q;
  assign finish_task_slot           = fin_slot_q;
  assign finish_task_undo_log_write = fin_write_q;
  assign overflow                   = ovf_q;

  a_start_in_idle: assert property (@(posedge clk) disable iff (!rstn)
    task_start_valid |-> state_q == CAP_IDLE)
    else $error("task_start_valid while capture is busy");

endmodule
